// File: rtl/dds_pkg.sv
// Shared types, defaults and helpers for the DDS waveform generator.
package dds_pkg;

  typedef enum logic [1:0] {
    SAW = 2'd0,
    TRI = 2'd1,
    SQR = 2'd2,
    SIN = 2'd3
  } wave_mode_e;

  localparam int DEF_DATA_W    = 14;
  localparam int DEF_PHASE_W   = 32;
  localparam int DEF_LUT_AW    = 10;
  localparam int DEF_AMP_W     = 8;
  localparam int DEF_DWELL_CYC = 50_000_000;

  // Auto-cycle order: saw -> tri -> sqr -> sin -> saw.
  function automatic wave_mode_e next_mode(wave_mode_e m);
    return wave_mode_e'(2'(m + 2'd1));
  endfunction

endpackage

// File: rtl/dds_wave_gen_if.sv
// Configuration handshake bundle for dds_wave_gen.
interface dds_wave_gen_if #(
  parameter int PHASE_W = 32,
  parameter int AMP_W   = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_mode;
  logic [PHASE_W-1:0] cfg_ftw;
  logic [AMP_W-1:0]   cfg_amp;
  logic               cfg_auto;
  logic               cfg_sync;

  modport master (output cfg_valid, cfg_mode, cfg_ftw, cfg_amp, cfg_auto, cfg_sync,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_mode, cfg_ftw, cfg_amp, cfg_auto, cfg_sync,
                  output cfg_ready);
endinterface

// File: rtl/sin_lut.sv
// Synchronous-read sine ROM, offset-binary, entry 0 = mid-scale.
module sin_lut #(
  parameter int DATA_W = 14,
  parameter int LUT_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LUT_AW-1:0] addr,
  output logic [DATA_W-1:0] q
);

  localparam real PI = 3.14159265358979;

  function automatic logic [DATA_W-1:0] sin_val(int i);
    real a;
    a = (2.0**(DATA_W-1) - 1.0) * $sin(((2.0 * PI) * real'(i)) / (2.0**LUT_AW));
    return DATA_W'((2**(DATA_W-1)) + $rtoi(a + ((a >= 0.0) ? 0.5 : -0.5)));
  endfunction

  logic [DATA_W-1:0] rom [2**LUT_AW];

  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
    assign rom[i] = sin_val(i);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else        q <= rom[addr];

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, four wave shapes, amplitude
// scaling, optional wrap-synchronous reconfiguration and auto mode cycling.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PHASE_W   = DEF_PHASE_W,
  parameter int LUT_AW    = DEF_LUT_AW,
  parameter int AMP_W     = DEF_AMP_W,
  parameter int DWELL_CYC = DEF_DWELL_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  dds_wave_gen_if.slave     cfg,
  output logic [DATA_W-1:0] DA_A,
  output logic              DA_CLK_A,
  output logic              DA_WR_A,
  output logic              sync_o
);

  localparam int DW_CW = $clog2(DWELL_CYC);
  localparam int PW    = DATA_W + AMP_W + 1;

  typedef struct packed {
    wave_mode_e         mode;
    logic [PHASE_W-1:0] ftw;
    logic [AMP_W-1:0]   amp;
    logic               auto_en;
  } cfg_t;

  cfg_t               act_q, pend_q, in_cfg, new_cfg;
  logic               pending_q;
  logic [PHASE_W-1:0] phase_q, phase_sum;
  logic               carry, wrap_q;
  logic [DW_CW-1:0]   dwell_q;
  logic               accept, apply_now, apply_pend, dwell_tc;

  assign DA_CLK_A      = clk;
  assign DA_WR_A       = ~clk;
  assign cfg.cfg_ready = ~pending_q;

  assign in_cfg.mode    = wave_mode_e'(cfg.cfg_mode);
  assign in_cfg.ftw     = cfg.cfg_ftw;
  assign in_cfg.amp     = cfg.cfg_amp;
  assign in_cfg.auto_en = cfg.cfg_auto;

  assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, act_q.ftw};
  assign accept     = cfg.cfg_valid & ~pending_q;
  assign apply_now  = accept & ~cfg.cfg_sync;
  // A zero tuning word never wraps, so a pending config lands right away.
  assign apply_pend = pending_q & (carry | (act_q.ftw == '0));
  assign new_cfg    = apply_now ? in_cfg : pend_q;
  assign dwell_tc   = act_q.auto_en & (dwell_q == DW_CW'(DWELL_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q     <= '{mode: SAW, ftw: '0, amp: '1, auto_en: 1'b0};
      pend_q    <= '0;
      pending_q <= 1'b0;
      phase_q   <= '0;
      wrap_q    <= 1'b0;
      dwell_q   <= '0;
    end else begin
      if (accept & cfg.cfg_sync) begin
        pending_q <= 1'b1;
        pend_q    <= in_cfg;
      end else if (apply_pend) begin
        pending_q <= 1'b0;
      end

      // Config apply beats dwell expiry and restarts the dwell.
      if (apply_now | apply_pend) begin
        act_q   <= new_cfg;
        dwell_q <= '0;
      end else if (dwell_tc) begin
        act_q.mode <= next_mode(act_q.mode);
        dwell_q    <= '0;
      end else if (act_q.auto_en) begin
        dwell_q <= dwell_q + DW_CW'(1);
      end else begin
        dwell_q <= '0;
      end

      phase_q <= apply_now ? '0 : phase_sum;
      wrap_q  <= carry & ~apply_now;
    end
  end

  // Stage 1: raw shape (sine comes from the registered ROM output).
  logic [DATA_W-1:0] p, tri_v, wf, wf_q, lut_q, raw2;
  wave_mode_e        mode_d1;
  logic [AMP_W-1:0]  amp_d1;
  logic              wrap_d1;
  logic [AMP_W:0]    amp_p1;
  logic [PW-1:0]     prod;

  assign p     = phase_q[PHASE_W-1 -: DATA_W];
  assign tri_v = {p[DATA_W-2:0], 1'b0};

  always_comb begin
    wf = p;
    case (act_q.mode)
      TRI:     wf = p[DATA_W-1] ? ~tri_v : tri_v;
      SQR:     wf = {DATA_W{p[DATA_W-1]}};
      default: wf = p;
    endcase
  end

  sin_lut #(.DATA_W(DATA_W), .LUT_AW(LUT_AW)) u_lut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (phase_q[PHASE_W-1 -: LUT_AW]),
    .q    (lut_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wf_q    <= '0;
      mode_d1 <= SAW;
      amp_d1  <= '0;
      wrap_d1 <= 1'b0;
      DA_A    <= '0;
      sync_o  <= 1'b0;
    end else begin
      wf_q    <= wf;
      mode_d1 <= act_q.mode;
      amp_d1  <= act_q.amp;
      wrap_d1 <= wrap_q;
      DA_A    <= DATA_W'(prod >> AMP_W);
      sync_o  <= wrap_d1;
    end
  end

  // Stage 2: scale by (amp+1)/2^AMP_W so all-ones amp is unity gain.
  assign raw2   = (mode_d1 == SIN) ? lut_q : wf_q;
  assign amp_p1 = {1'b0, amp_d1} + (AMP_W + 1)'(1);
  assign prod   = PW'(raw2) * PW'(amp_p1);

endmodule

// File: tb/tb_dds_wave_gen.sv
// Randomized scoreboard bench for dds_wave_gen against a cycle-level rule model.
module tb_dds_wave_gen;

  localparam int PHASE_W = 16, DATA_W = 14, LUT_AW = 10, AMP_W = 8, DWELL = 100;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DATA_W-1:0] da_a;
  logic da_clk, da_wr, sync_o;

  dds_wave_gen_if #(.PHASE_W(PHASE_W), .AMP_W(AMP_W)) cfg_if ();

  dds_wave_gen #(.DATA_W(DATA_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .AMP_W(AMP_W),
                 .DWELL_CYC(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg_if), .DA_A(da_a),
    .DA_CLK_A(da_clk), .DA_WR_A(da_wr), .sync_o(sync_o));

  always #5 clk = ~clk;

  typedef struct { int da; bit sy; } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int sin_tab[1024];

  // Reference model state
  int m_phase, m_ftw, m_mode, m_amp, m_dwell;
  bit m_auto, m_pend;
  int p_mode, p_ftw, p_amp;
  bit p_auto;

  // Stimulus for the next edge
  bit d_valid, d_auto, d_sync;
  int d_mode, d_ftw, d_amp;

  function automatic int wave(int mode, int ph, int amp);
    int pv, raw;
    pv = ph / 4;
    case (mode)
      0: raw = pv;
      1: raw = (pv < 8192) ? 2 * pv : 16383 - ((2 * pv) % 16384);
      2: raw = (pv < 8192) ? 0 : 16383;
      default: raw = sin_tab[ph / 64];
    endcase
    return (raw * (amp + 1)) / 256;
  endfunction

  task automatic chk(string name, int act, int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_ftw = 0; m_mode = 0; m_amp = 255; m_dwell = 0;
    m_auto = 0; m_pend = 0;
  endfunction

  function automatic void model_edge();
    int sum;
    bit acc, carry, wrap;
    acc = d_valid && !m_pend;
    sum = m_phase + m_ftw;
    carry = sum >= 65536;
    if (acc && !d_sync) begin
      m_mode = d_mode; m_ftw = d_ftw; m_amp = d_amp; m_auto = d_auto;
      m_phase = 0; m_dwell = 0; wrap = 0;
    end else begin
      m_phase = sum % 65536;
      wrap = carry;
      if (m_pend && (carry || m_ftw == 0)) begin
        m_mode = p_mode; m_ftw = p_ftw; m_amp = p_amp; m_auto = p_auto;
        m_pend = 0; m_dwell = 0;
      end else if (m_auto) begin
        if (m_dwell == DWELL - 1) begin m_mode = (m_mode + 1) % 4; m_dwell = 0; end
        else m_dwell++;
      end else m_dwell = 0;
      if (acc) begin
        m_pend = 1; p_mode = d_mode; p_ftw = d_ftw; p_amp = d_amp; p_auto = d_auto;
      end
    end
    exp_q.push_back('{wave(m_mode, m_phase, m_amp), wrap});
  endfunction

  // One clock: check ready, drive inputs, advance model, take the edge.
  task automatic step();
    @(negedge clk);
    chk("cfg_ready", int'(cfg_if.cfg_ready), int'(!m_pend));
    cfg_if.cfg_valid = d_valid;
    cfg_if.cfg_mode  = 2'(d_mode);
    cfg_if.cfg_ftw   = 16'(d_ftw);
    cfg_if.cfg_amp   = 8'(d_amp);
    cfg_if.cfg_auto  = d_auto;
    cfg_if.cfg_sync  = d_sync;
    model_edge();
    @(posedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic offer(int mode, int ftw, int amp, bit au, bit sy);
    d_valid = 1; d_mode = mode; d_ftw = ftw; d_amp = amp; d_auto = au; d_sync = sy;
    step();
    d_valid = 0;
  endtask

  // Called just after a posedge; holds reset for a few edges.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_DA_A", int'(da_a), 0);
    chk("rst_sync_o", int'(sync_o), 0);
    chk("rst_cfg_ready", int'(cfg_if.cfg_ready), 1);
    exp_q.delete();
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    exp_q.push_back('{0, 1'b0});
    exp_q.push_back('{wave(m_mode, m_phase, m_amp), 1'b0});
  endtask

  // Monitor: one pipeline output per cycle, compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("reset_DA_A", int'(da_a), 0);
        chk("reset_sync_o", int'(sync_o), 0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("DA_A", int'(da_a), e.da);
        chk("sync_o", int'(sync_o), int'(e.sy));
        chk("dac_clocks", int'({da_clk, da_wr}), 2);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++)
      sin_tab[i] = 8192 + int'($floor(8191.0 * $sin(((2.0 * PI) * i) / 1024.0) + 0.5));
    cfg_if.cfg_valid = 0; cfg_if.cfg_mode = 0; cfg_if.cfg_ftw = 0;
    cfg_if.cfg_amp = 0; cfg_if.cfg_auto = 0; cfg_if.cfg_sync = 0;
    d_valid = 0; d_mode = 0; d_ftw = 0; d_amp = 255; d_auto = 0; d_sync = 0;
    @(posedge clk);
    do_reset();
    run(3);

    // Deferred with ftw=0 lands on the next edge
    offer(0, 16'h0100, 255, 0, 1);
    run(20);

    // Immediate saw, then scaled square and random-amp triangle
    offer(0, 16'h0400, 255, 0, 0);
    run(140);
    offer(2, 16'h0400, 127, 0, 0);
    run(80);
    offer(1, 16'h0400, $urandom_range(0, 255), 0, 0);
    run(70);

    // Deferred switch to sine from phase 0x2000
    offer(0, 16'h0400, 255, 0, 0);
    for (int i = 0; i < 200 && m_phase != 16'h2000; i++) step();
    offer(3, 16'h0400, 255, 0, 1);
    run(90);

    // Auto cycling, then a config landing on the terminal count
    offer(0, 16'h0400, 255, 1, 0);
    run(450);
    for (int i = 0; i < 200 && m_dwell != DWELL - 1; i++) step();
    offer(2, 16'h0800, 200, 1, 0);
    run(250);

    // Random configurations
    for (int k = 0; k < 30; k++) begin
      int f;
      case ($urandom_range(0, 3))
        0: f = 0;
        1: f = $urandom_range(1, 65535);
        default: f = $urandom_range(1, 16) * 256;
      endcase
      offer($urandom_range(0, 3), f, $urandom_range(0, 255), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      run($urandom_range(20, 120));
    end

    // Reset while a deferred config is pending
    offer(0, 16'h0100, 255, 0, 0);
    run(5);
    offer(3, 16'h2000, 255, 0, 1);
    run(3);
    do_reset();
    run(20);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
